// File: rtl/program_loader.sv
// Streams a length-prefixed, XOR-checksummed program image from a byte port into instruction memory,
// holding the core in reset until a load completes with a good checksum.
module program_loader (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [9:0]  imem_addr,
  output logic [31:0] imem_wd,
  output logic        core_reset,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERR
  } state_t;

  state_t      r_state;
  logic [7:0]  r_lenLo;
  logic [10:0] r_len;
  logic [10:0] r_wordIdx;
  logic [1:0]  r_byteIdx;
  logic [31:0] r_buf;
  logic [7:0]  r_csum;

  logic        w_accept;
  logic [15:0] w_lenFull;
  logic [10:0] w_nextIdx;

  assign w_accept  = rx_valid & rx_ready;
  assign w_lenFull = {rx_data, r_lenLo};
  assign w_nextIdx = r_wordIdx + 11'd1;

  // Outputs are pure decodes of registered state, so they stay glitch-free and reset cleanly.
  assign rx_ready   = (r_state == LEN0) || (r_state == LEN1) ||
                      (r_state == DATA) || (r_state == CSUM);
  assign imem_we    = (r_state == WRITE);
  assign imem_addr  = r_wordIdx[9:0];
  assign imem_wd    = r_buf;
  assign core_reset = (r_state != DONE);
  assign done       = (r_state == DONE);
  assign error      = (r_state == ERR);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= IDLE;
      r_lenLo   <= 8'd0;
      r_len     <= 11'd0;
      r_wordIdx <= 11'd0;
      r_byteIdx <= 2'd0;
      r_buf     <= 32'd0;
      r_csum    <= 8'd0;
    end else begin
      case (r_state)
        IDLE, DONE, ERR: begin
          if (start) begin
            r_state   <= LEN0;
            r_wordIdx <= 11'd0;
            r_byteIdx <= 2'd0;
            r_csum    <= 8'd0;
          end
        end
        LEN0: begin
          if (w_accept) begin
            r_lenLo <= rx_data;
            r_state <= LEN1;
          end
        end
        LEN1: begin
          if (w_accept) begin
            if ((w_lenFull == 16'd0) || (w_lenFull > 16'd1024)) begin
              r_state <= ERR;
            end else begin
              r_len   <= w_lenFull[10:0];
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_accept) begin
            case (r_byteIdx)
              2'd0:    r_buf[7:0]   <= rx_data;
              2'd1:    r_buf[15:8]  <= rx_data;
              2'd2:    r_buf[23:16] <= rx_data;
              default: r_buf[31:24] <= rx_data;
            endcase
            r_csum    <= r_csum ^ rx_data;
            r_byteIdx <= r_byteIdx + 2'd1;
            if (r_byteIdx == 2'd3) begin
              r_state <= WRITE;
            end
          end
        end
        WRITE: begin
          r_wordIdx <= w_nextIdx;
          r_byteIdx <= 2'd0;
          r_state   <= (w_nextIdx == r_len) ? CSUM : DATA;
        end
        CSUM: begin
          if (w_accept) begin
            r_state <= (rx_data == r_csum) ? DONE : ERR;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: nominal, gapped multi-word, bad checksum/length,
// mid-load reset and the 1024-word boundary, with every imem write captured and checked.
`timescale 1ns/1ps
module tb_program_loader;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wd;
  logic        core_reset;
  logic        done;
  logic        error;

  int compareCount = 0;
  int errCount = 0;
  bit streamAbort;
  logic [9:0]  wrAddr[$];
  logic [31:0] wrData[$];
  logic [31:0] payload[0:1023];

  program_loader dut (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wd    (imem_wd),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  // Every cycle with imem_we high is one logged write, so double strobes show up as extra entries.
  always @(negedge clk) begin
    if (imem_we) begin
      wrAddr.push_back(imem_addr);
      wrData.push_back(imem_wd);
    end
  end

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] wrAddrAt(input int i);
    if (i < wrAddr.size()) return {22'd0, wrAddr[i]};
    return 'x;
  endfunction

  function automatic logic [31:0] wrDataAt(input int i);
    if (i < wrData.size()) return wrData[i];
    return 'x;
  endfunction

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b, input bit gaps);
    int waitCycles;
    if (streamAbort) return;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_data    = b;
    rx_valid   = 1'b1;
    waitCycles = 0;
    while (!rx_ready && waitCycles < 64) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!rx_ready) begin
      checkOutput("rxReadyTimeout", 32'(rx_ready), 32'd1);
      streamAbort = 1'b1;
      rx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] n, input int words, input logic [7:0] csum,
                               input bit gaps, input bit midStart, input bit doStart, input bit sendCsum);
    logic [31:0] word;
    streamAbort = 1'b0;
    if (doStart) pulseStart();
    sendByte(n[7:0], gaps);
    sendByte(n[15:8], gaps);
    for (int w = 0; w < words; w++) begin
      word = payload[w];
      for (int k = 0; k < 4; k++) begin
        sendByte(word[8*k +: 8], gaps);
        if (midStart && w == 0 && k == 1) pulseStart();
      end
    end
    if (sendCsum) sendByte(csum, gaps);
  endtask

  function automatic logic [31:0] bigWord(input int i);
    return (32'(i) * 32'h0101_0101) ^ 32'hC35A_0000;
  endfunction

  function automatic logic [7:0] xorAll(input int words);
    logic [7:0] acc = 8'd0;
    for (int w = 0; w < words; w++) begin
      acc = acc ^ payload[w][7:0] ^ payload[w][15:8] ^ payload[w][23:16] ^ payload[w][31:24];
    end
    return acc;
  endfunction

  initial begin
    int badCount;
    Reset_n  = 1'b0;
    start    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;

    @(negedge clk);
    checkOutput("rstRxReady",   32'(rx_ready),   32'd0);
    checkOutput("rstImemWe",    32'(imem_we),    32'd0);
    checkOutput("rstDone",      32'(done),       32'd0);
    checkOutput("rstError",     32'(error),      32'd0);
    checkOutput("rstCoreReset", 32'(core_reset), 32'd1);
    checkOutput("rstImemAddr",  32'(imem_addr),  32'd0);
    checkOutput("rstImemWd",    imem_wd,         32'd0);
    Reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idleRxReady",   32'(rx_ready),   32'd0);
    checkOutput("idleCoreReset", 32'(core_reset), 32'd1);

    $display("[TB] nominal single-word load");
    payload[0] = 32'h00A0_0513;
    wrAddr.delete(); wrData.delete();
    applyStimulus(16'd1, 1, 8'hB6, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("nomWrites",    32'(wrAddr.size()), 32'd1);
    checkOutput("nomAddr",      wrAddrAt(0),        32'd0);
    checkOutput("nomWord",      wrDataAt(0),        32'h00A0_0513);
    checkOutput("nomDone",      32'(done),          32'd1);
    checkOutput("nomCoreReset", 32'(core_reset),    32'd0);
    checkOutput("nomRxReady",   32'(rx_ready),      32'd0);

    $display("[TB] three words with rx_valid gaps and an ignored start");
    payload[0] = 32'h1122_3344;
    payload[1] = 32'hDEAD_BEEF;
    payload[2] = 32'h0000_FFFF;
    wrAddr.delete(); wrData.delete();
    applyStimulus(16'd3, 3, 8'h66, 1'b1, 1'b1, 1'b1, 1'b1);
    checkOutput("gapWrites", 32'(wrAddr.size()), 32'd3);
    checkOutput("gapAddr0",  wrAddrAt(0), 32'd0);
    checkOutput("gapAddr1",  wrAddrAt(1), 32'd1);
    checkOutput("gapAddr2",  wrAddrAt(2), 32'd2);
    checkOutput("gapWord0",  wrDataAt(0), 32'h1122_3344);
    checkOutput("gapWord1",  wrDataAt(1), 32'hDEAD_BEEF);
    checkOutput("gapWord2",  wrDataAt(2), 32'h0000_FFFF);
    checkOutput("gapDone",   32'(done),   32'd1);

    $display("[TB] bad checksum then recovery");
    payload[0] = 32'h00A0_0513;
    wrAddr.delete(); wrData.delete();
    applyStimulus(16'd1, 1, 8'hB7, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("csumWrites",    32'(wrAddr.size()), 32'd1);
    checkOutput("csumError",     32'(error),         32'd1);
    checkOutput("csumDone",      32'(done),          32'd0);
    checkOutput("csumCoreReset", 32'(core_reset),    32'd1);
    applyStimulus(16'd1, 1, 8'hB6, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("recoverDone",  32'(done),  32'd1);
    checkOutput("recoverError", 32'(error), 32'd0);

    $display("[TB] bad lengths 0 and 1025");
    wrAddr.delete(); wrData.delete();
    applyStimulus(16'd0, 0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("len0Error",   32'(error),    32'd1);
    checkOutput("len0RxReady", 32'(rx_ready), 32'd0);
    pulseStart();
    checkOutput("errClearedByStart", 32'(error),    32'd0);
    checkOutput("errRestartRxReady", 32'(rx_ready), 32'd1);
    applyStimulus(16'd1025, 0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("len1025Error",   32'(error),    32'd1);
    checkOutput("len1025RxReady", 32'(rx_ready), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("badLenWrites", 32'(wrAddr.size()), 32'd0);

    $display("[TB] reset in the middle of word 1");
    payload[0] = 32'hCAFE_F00D;
    payload[1] = 32'h1234_5678;
    wrAddr.delete(); wrData.delete();
    streamAbort = 1'b0;
    pulseStart();
    sendByte(8'h02, 1'b0);
    sendByte(8'h00, 1'b0);
    sendByte(8'h0D, 1'b0);
    sendByte(8'hF0, 1'b0);
    sendByte(8'hFE, 1'b0);
    sendByte(8'hCA, 1'b0);
    sendByte(8'h78, 1'b0);
    sendByte(8'h56, 1'b0);
    Reset_n = 1'b0;
    #1;
    checkOutput("midRstRxReady",   32'(rx_ready),   32'd0);
    checkOutput("midRstCoreReset", 32'(core_reset), 32'd1);
    checkOutput("midRstImemWe",    32'(imem_we),    32'd0);
    repeat (3) @(negedge clk);
    Reset_n = 1'b1;
    repeat (4) @(negedge clk);
    checkOutput("midRstWrites",    32'(wrAddr.size()), 32'd1);
    checkOutput("midRstWord0",     wrDataAt(0),        32'hCAFE_F00D);
    checkOutput("postRstRxReady",  32'(rx_ready),      32'd0);
    checkOutput("postRstCoreReset",32'(core_reset),    32'd1);
    payload[0] = 32'h00A0_0513;
    applyStimulus(16'd1, 1, 8'hB6, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("postRstDone", 32'(done), 32'd1);
    pulseStart();
    checkOutput("doneRestartCoreReset", 32'(core_reset), 32'd1);
    checkOutput("doneRestartDone",      32'(done),       32'd0);
    applyStimulus(16'd1, 1, 8'hB6, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("doneRestartLoad", 32'(done), 32'd1);

    $display("[TB] 1024-word boundary");
    for (int i = 0; i < 1024; i++) payload[i] = bigWord(i);
    wrAddr.delete(); wrData.delete();
    applyStimulus(16'd1024, 1024, xorAll(1024), 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("bigWrites",   32'(wrAddr.size()), 32'd1024);
    checkOutput("bigFirstAddr", wrAddrAt(0),       32'd0);
    checkOutput("bigLastAddr",  wrAddrAt(1023),    32'd1023);
    badCount = 0;
    for (int i = 0; i < wrAddr.size(); i++) begin
      if (wrAddr[i] !== 10'(i) || wrData[i] !== bigWord(i)) badCount++;
    end
    checkOutput("bigBadEntries", 32'(badCount),   32'd0);
    checkOutput("bigDone",       32'(done),       32'd1);
    checkOutput("bigCoreReset",  32'(core_reset), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, errCount);
    $finish;
  end

endmodule
